banner_rect_gen: RTL and testbench

- Animated rectangle generator that drives the bitmap-drawer interface: offsetX, offsetY and InsideRectangle for a 64x32 one-bit banner bitmap (e.g. the "lose" banner).
- On trigger, the banner slides down to its target position one step per frame, blinks a fixed number of times, then holds until cleared.
- Sits between the VGA pixel counters and the banner bitmap block; the bitmap block's drawingRequest/RGBout feed the existing object mux unchanged.

---
 rtl/banner_rect_gen_if.sv | 31 +++
 rtl/banner_rect_gen.sv | 178 +++++++++++++++++
 tb/tb_banner_rect_gen.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/banner_rect_gen_if.sv
// ---------------------------------------------------------------------------
// banner_rect_gen_if
// Pixel bus between the VGA pixel counters and the banner rectangle generator.
//   pixelX / pixelY     : current VGA pixel coordinates (from counters)
//   offsetX / offsetY   : pixel position relative to the banner's top-left
//   InsideRectangle     : current pixel lies inside the visible banner
// master = pixel-counter side, slave = rectangle generator.
// ---------------------------------------------------------------------------
interface banner_rect_gen_if;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        InsideRectangle;

    modport master (
        output pixelX,
        output pixelY,
        input  offsetX,
        input  offsetY,
        input  InsideRectangle
    );

    modport slave (
        input  pixelX,
        input  pixelY,
        output offsetX,
        output offsetY,
        output InsideRectangle
    );
endinterface

// File: rtl/banner_rect_gen.sv
// ---------------------------------------------------------------------------
// banner_rect_gen
// Animated rectangle generator for a 64x32 one-bit banner bitmap. On trigger
// the banner slides down one step per frame to its target row, blinks a fixed
// number of times and then holds until cleared.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   startOfFrame    : one-cycle pulse at the start of every VGA frame
//   trigger         : one-cycle pulse, start the animation (IDLE only)
//   clear           : one-cycle pulse, hide banner and return to IDLE
//   pix             : pixel bus (pixelX/Y in, offsetX/Y and InsideRectangle
//                     out, registered with one cycle of latency)
//   bannerActive    : animation is running or holding
//   animDone        : animation finished, banner holding
// ---------------------------------------------------------------------------
module banner_rect_gen #(
    parameter int OBJECT_WIDTH  = 64,
    parameter int OBJECT_HEIGHT = 32,
    parameter int TARGET_X      = 288,
    parameter int TARGET_Y      = 224,
    parameter int START_Y       = 0,
    parameter int SLIDE_STEP    = 4,
    parameter int BLINK_FRAMES  = 16,
    parameter int BLINK_COUNT   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              startOfFrame,
    input  logic              trigger,
    input  logic              clear,
    banner_rect_gen_if.slave  pix,
    output logic              bannerActive,
    output logic              animDone
);

    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam int TW = $clog2(2 * BLINK_COUNT + 1);

    localparam logic [10:0] TX      = 11'(TARGET_X);
    localparam logic [10:0] TY      = 11'(TARGET_Y);
    localparam logic [10:0] SY      = 11'(START_Y);
    localparam logic [11:0] X_HI    = 12'(TARGET_X + OBJECT_WIDTH);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [TW-1:0] TOGGLE_END = TW'(2 * BLINK_COUNT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SLIDE,
        S_BLINK,
        S_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [10:0]     top_y_q, top_y_d;
    logic            visible_q, visible_d;
    logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
    logic [TW-1:0]   toggle_cnt_q, toggle_cnt_d;

    logic [10:0]     offset_x_q, offset_y_q;
    logic            inside_q;
    logic            active_q, done_q;

    logic [11:0]     step_sum;
    logic [11:0]     y_hi;
    logic            hit;

    // Slide sum kept 12 bits wide so a large step can never wrap past TARGET_Y.
    assign step_sum = {1'b0, top_y_q} + 12'(SLIDE_STEP);

    // ------------------------------------------------------------------
    // Animation FSM, next-state logic. Position/visibility only move on
    // startOfFrame so a frame is never drawn with a half-updated banner.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        top_y_d      = top_y_q;
        visible_d    = visible_q;
        frame_cnt_d  = frame_cnt_q;
        toggle_cnt_d = toggle_cnt_q;

        if (clear) begin
            state_d      = S_IDLE;
            top_y_d      = SY;
            visible_d    = 1'b0;
            frame_cnt_d  = '0;
            toggle_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    visible_d = 1'b0;
                    if (trigger) begin
                        state_d   = S_SLIDE;
                        top_y_d   = SY;
                        visible_d = 1'b1;
                    end
                end
                S_SLIDE: begin
                    if (startOfFrame) begin
                        if (top_y_q == TY) begin
                            state_d      = S_BLINK;
                            frame_cnt_d  = '0;
                            toggle_cnt_d = '0;
                        end else if (step_sum >= {1'b0, TY}) begin
                            top_y_d = TY;
                        end else begin
                            top_y_d = step_sum[10:0];
                        end
                    end
                end
                S_BLINK: begin
                    if (startOfFrame) begin
                        if (frame_cnt_q == FRAME_LAST) begin
                            frame_cnt_d  = '0;
                            visible_d    = ~visible_q;
                            toggle_cnt_d = toggle_cnt_q + 1'b1;
                            // Even toggle count means visible again: done.
                            if (toggle_cnt_q + 1'b1 == TOGGLE_END) begin
                                state_d = S_HOLD;
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_q + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    visible_d = 1'b1;
                end
                default: begin
                    state_d   = S_IDLE;
                    visible_d = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pixel hit test against the registered position; upper bounds 12 bits.
    // ------------------------------------------------------------------
    assign y_hi = {1'b0, top_y_q} + 12'(OBJECT_HEIGHT);
    assign hit  = visible_q
               && (pix.pixelX >= TX)
               && ({1'b0, pix.pixelX} < X_HI)
               && (pix.pixelY >= top_y_q)
               && ({1'b0, pix.pixelY} < y_hi);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            top_y_q      <= SY;
            visible_q    <= 1'b0;
            frame_cnt_q  <= '0;
            toggle_cnt_q <= '0;
            offset_x_q   <= '0;
            offset_y_q   <= '0;
            inside_q     <= 1'b0;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            top_y_q      <= top_y_d;
            visible_q    <= visible_d;
            frame_cnt_q  <= frame_cnt_d;
            toggle_cnt_q <= toggle_cnt_d;
            inside_q     <= hit;
            offset_x_q   <= hit ? pix.pixelX - TX      : '0;
            offset_y_q   <= hit ? pix.pixelY - top_y_q : '0;
            active_q     <= (state_d != S_IDLE);
            done_q       <= (state_d == S_HOLD);
        end
    end

    assign pix.offsetX         = offset_x_q;
    assign pix.offsetY         = offset_y_q;
    assign pix.InsideRectangle = inside_q;
    assign bannerActive        = active_q;
    assign animDone            = done_q;

endmodule

// File: tb/tb_banner_rect_gen.sv
// ---------------------------------------------------------------------------
// tb_banner_rect_gen
// Directed bench for banner_rect_gen. Two instances: dut_a with default
// parameters, dut_b with SLIDE_STEP=5 to exercise the clamp at TARGET_Y.
// Each probe drives a pixel, pushes the expected registered response into a
// scoreboard queue, and a separate monitor pops/compares one cycle later.
// ---------------------------------------------------------------------------
module tb_banner_rect_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, sof, trig_a, trig_b, clear;
    logic act_a, done_a, act_b, done_b;

    banner_rect_gen_if ifa ();
    banner_rect_gen_if ifb ();

    banner_rect_gen dut_a (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (sof),
        .trigger      (trig_a),
        .clear        (clear),
        .pix          (ifa),
        .bannerActive (act_a),
        .animDone     (done_a)
    );

    banner_rect_gen #(.SLIDE_STEP(5)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (sof),
        .trigger      (trig_b),
        .clear        (clear),
        .pix          (ifb),
        .bannerActive (act_b),
        .animDone     (done_b)
    );

    typedef struct {
        int          dut;
        string       tag;
        logic        ins;
        logic [10:0] ox;
        logic [10:0] oy;
        logic        act;
        logic        done;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic probe_v = 1'b0;
    logic probe_v_d = 1'b0;

    // Marks the cycle in which the DUT presents the response to a probe.
    always @(posedge clk) probe_v_d <= probe_v;

    // ---------------- monitor ----------------
    exp_t        m_e;
    logic        m_ins, m_act, m_done;
    logic [10:0] m_ox, m_oy;

    always @(negedge clk) begin
        if (probe_v_d) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: got response with no expected entry, want entry");
            end else begin
                m_e = sb.pop_front();
                if (m_e.dut == 0) begin
                    m_ins = ifa.InsideRectangle; m_ox = ifa.offsetX; m_oy = ifa.offsetY;
                    m_act = act_a; m_done = done_a;
                end else begin
                    m_ins = ifb.InsideRectangle; m_ox = ifb.offsetX; m_oy = ifb.offsetY;
                    m_act = act_b; m_done = done_b;
                end
                if (m_ins !== m_e.ins || m_ox !== m_e.ox || m_oy !== m_e.oy ||
                    m_act !== m_e.act || m_done !== m_e.done) begin
                    errors++;
                    $display("FAIL %s: got ins=%0b ox=%0d oy=%0d act=%0b done=%0b, want ins=%0b ox=%0d oy=%0d act=%0b done=%0b",
                             m_e.tag, m_ins, m_ox, m_oy, m_act, m_done,
                             m_e.ins, m_e.ox, m_e.oy, m_e.act, m_e.done);
                end else begin
                    $display("check %0d %s ok: ins=%0b ox=%0d oy=%0d act=%0b done=%0b",
                             checks, m_e.tag, m_ins, m_ox, m_oy, m_act, m_done);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic probe(input int d, input string tag, input int px, input int py,
                         input logic ins, input int ox, input int oy,
                         input logic act, input logic done);
        exp_t e;
        ifa.pixelX = 11'(px); ifa.pixelY = 11'(py);
        ifb.pixelX = 11'(px); ifb.pixelY = 11'(py);
        e.dut = d; e.tag = tag; e.ins = ins;
        e.ox = 11'(ox); e.oy = 11'(oy); e.act = act; e.done = done;
        sb.push_back(e);
        probe_v = 1'b1;
        @(negedge clk);
        probe_v = 1'b0;
    endtask

    task automatic frame();
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
    endtask

    task automatic pulse_trig_a();
        trig_a = 1'b1;
        @(negedge clk);
        trig_a = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Watchdog: the run is fixed-length, this only guards against a hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  y, t2;
        logic in2, vis;

        reset = 1'b1; sof = 1'b0; trig_a = 1'b0; trig_b = 1'b0; clear = 1'b0;
        ifa.pixelX = 11'd300; ifa.pixelY = 11'd230;
        ifb.pixelX = 11'd300; ifb.pixelY = 11'd230;
        @(negedge clk);
        probe(0, "reset_a", 300, 230, 0, 0, 0, 0, 0);
        probe(1, "reset_b", 300, 230, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // trigger and clear together in IDLE: clear wins
        trig_a = 1'b1; trig_b = 1'b1; clear = 1'b1;
        @(negedge clk);
        trig_a = 1'b0; trig_b = 1'b0; clear = 1'b0;
        probe(0, "trig_clear_idle", 300, 230, 0, 0, 0, 0, 0);

        // trigger with a coincident startOfFrame: no step on entry
        trig_a = 1'b1; trig_b = 1'b1; sof = 1'b1;
        @(negedge clk);
        trig_a = 1'b0; trig_b = 1'b0; sof = 1'b0;
        probe(0, "slide_start_a", 288, 0, 1, 0, 0, 1, 0);
        probe(1, "slide_start_b", 288, 0, 1, 0, 0, 1, 0);

        // slide: A steps 4/frame, B steps 5/frame and must clamp at 224
        for (int k = 1; k <= 56; k++) begin
            frame();
            y = 4 * k;
            probe(0, $sformatf("slide_a_k%0d", k), 288, y, 1, 0, 0, 1, 0);
            t2 = (5 * k > 224) ? 224 : 5 * k;
            in2 = (y >= t2) && (y < t2 + 32);
            probe(1, $sformatf("slide_b_k%0d", k), 288, y, in2, 0, in2 ? y - t2 : 0, 1, 0);
        end

        // 57th frame pulse: enter BLINK, still visible
        frame();
        probe(0, "blink_entry", 300, 230, 1, 12, 6, 1, 0);

        // blink: 16 frames per half-period, 3 off/on cycles, trigger ignored
        for (int f = 1; f <= 96; f++) begin
            if (f == 20) pulse_trig_a();
            frame();
            vis = ((f / 16) % 2) == 0;
            probe(0, $sformatf("blink_f%0d", f), 300, 230, vis,
                  vis ? 12 : 0, vis ? 6 : 0, 1, f == 96);
        end

        // geometry in HOLD
        probe(0, "hold_tl",     288, 224, 1, 0,  0,  1, 1);
        probe(0, "hold_br",     351, 255, 1, 63, 31, 1, 1);
        probe(0, "hold_right",  352, 224, 0, 0,  0,  1, 1);
        probe(0, "hold_left",   287, 224, 0, 0,  0,  1, 1);
        probe(0, "hold_below",  288, 256, 0, 0,  0,  1, 1);
        frame();
        frame();
        probe(0, "hold_stays",  300, 230, 1, 12, 6,  1, 1);

        pulse_clear();
        probe(0, "clear_hold",  300, 230, 0, 0, 0, 0, 0);

        // clear mid-slide at topY=100
        pulse_trig_a();
        repeat (25) frame();
        probe(0, "slide_100",    288, 100, 1, 0, 0, 1, 0);
        pulse_clear();
        probe(0, "clear_slide",  288, 100, 0, 0, 0, 0, 0);
        probe(0, "clear_slide2", 300, 110, 0, 0, 0, 0, 0);

        // reset mid-BLINK while hidden (toggleCnt=3)
        pulse_trig_a();
        repeat (57) frame();
        repeat (48) frame();
        probe(0, "blink_t3_hidden", 300, 230, 0, 0, 0, 1, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        probe(0, "reset_mid_blink", 300, 230, 0, 0, 0, 0, 0);
        pulse_trig_a();
        probe(0, "retrigger_top0", 288, 0, 1, 0, 0, 1, 0);
        frame();
        probe(0, "retrigger_step", 288, 4, 1, 0, 0, 1, 0);

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
